// File: rtl/if_fetch_stage.sv
// if_fetch_stage: holds the PC, runs the imem req/ack handshake and presents {pc, inst} to IF/ID.
// Optional perf counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic [31:0]       perf_fetches,
  output logic [31:0]       perf_squashes
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, addr_n, out_pc_n;
  logic [DATA_W-1:0] out_inst_n;
  logic squash, squash_n, req_n, out_valid_n;
  always_comb begin
    state_n = state;
    pc_n = pc;
    addr_n = imem_addr;
    squash_n = squash;
    req_n = imem_req;
    out_valid_n = out_valid;
    out_pc_n = out_pc;
    out_inst_n = out_inst;
    if (redirect_valid) begin
      pc_n = redirect_pc;
      out_valid_n = 1'b0;
    end
    case (state)
      IDLE: begin
        state_n = WAIT;
        req_n = 1'b1;
        addr_n = redirect_valid ? redirect_pc : pc;
      end
      WAIT: begin
        req_n = 1'b1;
        // an outstanding request cannot be retargeted, so a redirect without ack only marks it for dropping
        if (redirect_valid) begin
          squash_n = !imem_ack;
          addr_n = imem_ack ? redirect_pc : imem_addr;
        end else if (imem_ack && squash) begin
          squash_n = 1'b0;
          addr_n = pc;
        end else if (imem_ack) begin
          out_inst_n = imem_rdata;
          out_pc_n = imem_addr;
          out_valid_n = 1'b1;
          pc_n = pc + ADDR_W'(PC_INC);
          req_n = 1'b0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || !stall) begin
          state_n = WAIT;
          req_n = 1'b1;
          out_valid_n = 1'b0;
          addr_n = redirect_valid ? redirect_pc : pc;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      squash <= 1'b0;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      out_valid <= 1'b0;
      out_pc <= '0;
      out_inst <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      squash <= squash_n;
      imem_req <= req_n;
      imem_addr <= addr_n;
      out_valid <= out_valid_n;
      out_pc <= out_pc_n;
      out_inst <= out_inst_n;
    end
  end
`ifdef IF_PERF_CNT_EN
  logic fetch_evt, squash_evt;
  assign fetch_evt = state == HOLD && !stall && !redirect_valid;
  assign squash_evt = (state == WAIT && imem_ack && (squash || redirect_valid)) || (state == HOLD && redirect_valid);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetches <= '0;
      perf_squashes <= '0;
    end else begin
      if (fetch_evt && perf_fetches != '1) perf_fetches <= perf_fetches + 32'd1;
      if (squash_evt && perf_squashes != '1) perf_squashes <= perf_squashes + 32'd1;
    end
  end
`else
  assign perf_fetches = '0;
  assign perf_squashes = '0;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of fetch, stall, redirect/squash, async reset and PC wrap.
module tb_if_fetch_stage;
`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic auto_ack = 1'b1, man_ack = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic imem_req, imem_ack, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_pc, out_inst, perf_fetches, perf_squashes;
  logic redir4 = 1'b0, req4, valid4;
  logic [3:0] redir_pc4 = '0, addr4, out_pc4;
  logic [7:0] inst4;
  logic [31:0] pf4, ps4;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign imem_ack = auto_ack ? imem_req : man_ack;
  assign imem_rdata = imem_addr + 32'd100;
  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .perf_fetches(perf_fetches), .perf_squashes(perf_squashes));
  if_fetch_stage #(.ADDR_W(4), .DATA_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect_valid(redir4), .redirect_pc(redir_pc4),
    .imem_req(req4), .imem_addr(addr4), .imem_ack(req4), .imem_rdata({4'hA, addr4}),
    .out_valid(valid4), .out_pc(out_pc4), .out_inst(inst4),
    .perf_fetches(pf4), .perf_squashes(ps4));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    chk({tag, "_valid"}, out_valid, v);
    chk({tag, "_pc"}, out_pc, p);
    chk({tag, "_inst"}, out_inst, i);
  endtask
  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, imem_req, r);
    chk({tag, "_addr"}, imem_addr, a);
  endtask
  initial begin
    tick();
    tick();
    chk_req("rst", 1'b0, 32'd0);
    chk_out("rst", 1'b0, 32'd0, 32'd0);
    chk("rst_pf", perf_fetches, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_req("first_req", 1'b1, 32'd0);
    chk("first_nv", out_valid, 1'b0);
    tick();
    chk_out("seq0", 1'b1, 32'd0, 32'd100);
    chk("seq0_req", imem_req, 1'b0);
    tick();
    chk("gap0_valid", out_valid, 1'b0);
    chk_req("gap0", 1'b1, 32'd1);
    tick();
    chk_out("seq1", 1'b1, 32'd1, 32'd101);
    tick();
    tick();
    chk_out("seq2", 1'b1, 32'd2, 32'd102);
    tick();
    tick();
    chk_out("seq3", 1'b1, 32'd3, 32'd103);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("stall", 1'b1, 32'd3, 32'd103);
      chk("stall_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    tick();
    chk_req("unstall", 1'b1, 32'd4);
    chk("unstall_nv", out_valid, 1'b0);
    tick();
    chk_out("seq4", 1'b1, 32'd4, 32'd104);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd40;
    tick();
    chk("rdh_nv", out_valid, 1'b0);
    chk_req("rdh", 1'b1, 32'd40);
    redirect_valid = 1'b0;
    stall = 1'b0;
    tick();
    chk_out("rdh_dlv", 1'b1, 32'd40, 32'd140);
    tick();
    chk_req("pend", 1'b1, 32'd41);
    auto_ack = 1'b0;
    man_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'd80;
    tick();
    chk_req("sq_hold0", 1'b1, 32'd41);
    chk("sq_nv0", out_valid, 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk_req("sq_hold1", 1'b1, 32'd41);
    man_ack = 1'b1;
    tick();
    chk_req("sq_drop", 1'b1, 32'd80);
    chk("sq_drop_nv", out_valid, 1'b0);
    man_ack = 1'b0;
    tick();
    chk_req("sq_wait", 1'b1, 32'd80);
    chk("sq_wait_nv", out_valid, 1'b0);
    man_ack = 1'b1;
    tick();
    chk_out("sq_dlv", 1'b1, 32'd80, 32'd180);
    man_ack = 1'b0;
    tick();
    chk_req("c80", 1'b1, 32'd81);
    man_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd90;
    tick();
    chk_req("rd_ack", 1'b1, 32'd90);
    chk("rd_ack_nv", out_valid, 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk_out("rd_ack_dlv", 1'b1, 32'd90, 32'd190);
    man_ack = 1'b0;
    tick();
    chk_req("pre_rst", 1'b1, 32'd91);
    chk("perf_f", perf_fetches, PERF ? 32'd7 : 32'd0);
    chk("perf_s", perf_squashes, PERF ? 32'd3 : 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_req("arst", 1'b0, 32'd0);
    chk("arst_nv", out_valid, 1'b0);
    chk("arst_ps", perf_squashes, 32'd0);
    tick();
    rst_n = 1'b1;
    auto_ack = 1'b1;
    tick();
    chk_req("restart", 1'b1, 32'd0);
    redir4 = 1'b1;
    redir_pc4 = 4'd15;
    tick();
    chk_out("restart_dlv", 1'b1, 32'd0, 32'd100);
    chk("w_addr15", addr4, 4'd15);
    chk("w_nv", valid4, 1'b0);
    redir4 = 1'b0;
    tick();
    chk("w_pc15", out_pc4, 4'd15);
    chk("w_inst15", inst4, 8'hAF);
    chk("w_v15", valid4, 1'b1);
    tick();
    chk("w_addr0", addr4, 4'd0);
    chk("w_req0", req4, 1'b1);
    tick();
    chk("w_pc0", out_pc4, 4'd0);
    chk("w_inst0", inst4, 8'hA0);
    chk("w_v0", valid4, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
